// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit for the single-cycle
// MIPS datapath. It takes the rs/rt register-file operands and runs
// MULT/MULTU as 32 radix-2 shift-add steps and DIV/DIVU as 32 radix-2
// restoring shift-subtract steps. A final fix-up cycle applies the sign
// correction. The unit also holds the architectural HI/LO registers.
//
// Ports:
//   Clock        system clock; all state changes on its rising edge
//   Reset        asynchronous, active-high reset
//   Start        single-cycle request; only looked at while Busy=0
//   Op           000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
//   Operand_A    rs value (multiplicand / dividend / MTHI-MTLO source)
//   Operand_B    rt value (multiplier / divisor)
//   Busy         operation in progress; the PC is stalled while high
//   Done         one-cycle pulse once Hi/Lo hold the new result
//   Div_By_Zero  qualifies Done: the divisor was zero
//   Hi, Lo       architectural HI and LO registers
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] Operand_A,
   input  logic [WIDTH-1:0] Operand_B,
   output logic             Busy,
   output logic             Done,
   output logic             Div_By_Zero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] opb;
   logic             is_div;
   logic             neg_main;
   logic             neg_rem;
   logic             div_by_zero_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             accept, is_mul_req, is_div_req, zero_div_req, long_req;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fixed;
   logic [WIDTH-1:0] quo_fixed, rem_fixed;

   // A request is accepted whenever the unit is not busy, which includes
   // the single DONE cycle so back-to-back operations lose no cycle.
   assign accept       = Start && ((state == IDLE) || (state == DONE));
   assign is_mul_req   = (Op[2:1] == 2'b00);
   assign is_div_req   = (Op[2:1] == 2'b01);
   assign zero_div_req = accept && is_div_req && (Operand_B == '0);
   assign long_req     = accept && (is_mul_req || (is_div_req && (Operand_B != '0)));

   // Signed ops run on magnitudes. -0x80000000 is 0x80000000 as an unsigned
   // magnitude, so the most negative value needs no special case.
   assign a_neg = Op[0] && Operand_A[WIDTH-1];
   assign b_neg = Op[0] && Operand_B[WIDTH-1];
   assign a_mag = a_neg ? -Operand_A : Operand_A;
   assign b_mag = b_neg ? -Operand_B : Operand_B;

   // Multiply step: {acc, quo} is the product register and quo[0] is the
   // current multiplier bit. The extra acc bit keeps the add carry before
   // the shift.
   assign mul_sum = acc + (quo[0] ? {1'b0, opb} : '0);

   // Divide step: acc is the partial remainder and quo shifts the dividend
   // out and the quotient in. A set top bit of the difference means the
   // trial subtraction went negative, so the shifted value is kept.
   assign div_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb};

   // Sign fix-up applied in FIX. The remainder follows the dividend sign.
   assign prod       = {acc[WIDTH-1:0], quo};
   assign prod_fixed = neg_main ? -prod : prod;
   assign quo_fixed  = neg_main ? -quo : quo;
   assign rem_fixed  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

   // State register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic. A zero divisor skips the iteration and goes straight
   // to DONE, so Busy never rises for that case.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            next_state = IDLE;
            if (long_req)
               next_state = CALC;
            else if (zero_div_req)
               next_state = DONE;
         end
         CALC:    if (count == CNT_W'(WIDTH - 1)) next_state = FIX;
         FIX:     next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   // Iteration datapath: load the operands on acceptance, then run one
   // radix-2 step per CALC cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count    <= '0;
         acc      <= '0;
         quo      <= '0;
         opb      <= '0;
         is_div   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
      end else if (long_req) begin
         count    <= '0;
         acc      <= '0;
         quo      <= a_mag;
         opb      <= b_mag;
         is_div   <= is_div_req;
         neg_main <= a_neg ^ b_neg;
         neg_rem  <= a_neg;
      end else if (state == CALC) begin
         count <= count + 1'b1;
         if (is_div) begin
            if (!div_diff[WIDTH]) begin
               acc <= div_diff;
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               acc <= div_shift;
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
         end
      end
   end

   // HI/LO change only at FIX or on a move-to. On a zero divisor they hold.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state == FIX) begin
         if (is_div) begin
            hi_q <= rem_fixed;
            lo_q <= quo_fixed;
         end else begin
            {hi_q, lo_q} <= prod_fixed;
         end
      end else if (accept && (Op == OP_MTHI)) begin
         hi_q <= Operand_A;
      end else if (accept && (Op == OP_MTLO)) begin
         lo_q <= Operand_A;
      end
   end

   // The divide-by-zero flag is re-evaluated on every accept opportunity.
   // A non-zero-divisor start from DONE therefore clears it together with
   // Done.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         div_by_zero_q <= 1'b0;
      else if ((state == IDLE) || (state == DONE))
         div_by_zero_q <= zero_div_req;
   end

   assign Busy        = (state == CALC) || (state == FIX);
   assign Done        = (state == DONE);
   assign Div_By_Zero = div_by_zero_q;
   assign Hi          = hi_q;
   assign Lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Directed cases
// plus randomized operations are compared against a plain-arithmetic HI/LO
// model.
module tb_mult_div_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] Operand_A, Operand_B;
   logic        Busy, Done, Div_By_Zero;
   logic [31:0] Hi, Lo;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
      .Operand_A(Operand_A), .Operand_B(Operand_B),
      .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero),
      .Hi(Hi), .Lo(Lo)
   );

   always #5 Clock = ~Clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Operand source biased toward corner values.
   function automatic logic [31:0] pickValue();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0:       v = 32'h0;
         1:       v = 32'hFFFFFFFF;
         2:       v = 32'h80000000;
         3:       v = 32'h7FFFFFFF;
         4:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issues one request at the current falling edge and checks the outcome.
   // Expected HI/LO come from plain integer arithmetic. When intrude_at > 0,
   // a DIVU 9/2 request is raised after that many Busy cycles and must be
   // ignored. The task returns on a falling edge: the DONE cycle for
   // multiply/divide, otherwise the cycle after the request.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int intrude_at);
      int          kind;
      int          busy_cycles;
      int          guard;
      logic [63:0] p;
      longint      sa, sb, q, r;
      kind = 0;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      case (op)
         3'd0: begin
            p = {32'b0, a} * {32'b0, b};
            model_hi = p[63:32]; model_lo = p[31:0]; kind = 2;
         end
         3'd1: begin
            p = sa * sb;
            model_hi = p[63:32]; model_lo = p[31:0]; kind = 2;
         end
         3'd2: begin
            if (b == 0) kind = 1;
            else begin model_lo = a / b; model_hi = a % b; kind = 2; end
         end
         3'd3: begin
            if (b == 0) kind = 1;
            else begin
               q = sa / sb; r = sa % sb;
               model_lo = 32'(q); model_hi = 32'(r); kind = 2;
            end
         end
         3'd4:    model_hi = a;
         3'd5:    model_lo = a;
         default: kind = 0;
      endcase
      Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
      @(negedge Clock);
      Start = 1'b0; Op = 3'($urandom); Operand_A = $urandom; Operand_B = $urandom;
      if (kind == 2) begin
         busy_cycles = 0;
         guard = 0;
         while (!Done && guard < 100) begin
            if (Start) Start = 1'b0;
            if (Busy) busy_cycles++;
            if (busy_cycles == intrude_at) begin
               Start = 1'b1; Op = 3'b010; Operand_A = 32'd9; Operand_B = 32'd2;
            end
            guard++;
            @(negedge Clock);
         end
         Start = 1'b0;
         checkOutput($sformatf("busy_len op%0d", op), 64'(busy_cycles), 64'd33);
         checkOutput($sformatf("done op%0d", op), 64'(Done), 64'd1);
         checkOutput($sformatf("busy_with_done op%0d", op), 64'(Busy), 64'd0);
         checkOutput($sformatf("dbz_clear op%0d", op), 64'(Div_By_Zero), 64'd0);
      end else if (kind == 1) begin
         checkOutput($sformatf("dbz_done op%0d", op), 64'(Done), 64'd1);
         checkOutput($sformatf("dbz_flag op%0d", op), 64'(Div_By_Zero), 64'd1);
         checkOutput($sformatf("dbz_busy op%0d", op), 64'(Busy), 64'd0);
      end else begin
         checkOutput($sformatf("imm_done op%0d", op), 64'(Done), 64'd0);
         checkOutput($sformatf("imm_busy op%0d", op), 64'(Busy), 64'd0);
      end
      checkOutput($sformatf("hi op%0d a=%0h b=%0h", op, a, b), 64'(Hi), 64'(model_hi));
      checkOutput($sformatf("lo op%0d a=%0h b=%0h", op, a, b), 64'(Lo), 64'(model_lo));
   endtask

   initial begin
      int done_seen;
      Reset = 1'b1; Start = 1'b0; Op = 3'b000; Operand_A = '0; Operand_B = '0;
      #12;
      checkOutput("reset_hi", 64'(Hi), 64'd0);
      checkOutput("reset_lo", 64'(Lo), 64'd0);
      checkOutput("reset_busy", 64'(Busy), 64'd0);
      checkOutput("reset_done", 64'(Done), 64'd0);
      checkOutput("reset_dbz", 64'(Div_By_Zero), 64'd0);
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);

      // Directed corner cases with literal expectations.
      applyStimulus(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
      checkOutput("multu_max_hi", 64'(Hi), 64'hFFFFFFFE);
      checkOutput("multu_max_lo", 64'(Lo), 64'h00000001);
      applyStimulus(3'd1, 32'hFFFFFFFD, 32'd7, -1);
      checkOutput("mult_neg_lo", 64'(Lo), 64'hFFFFFFEB);
      applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, -1);
      checkOutput("div_neg_lo", 64'(Lo), 64'hFFFFFFFD);
      checkOutput("div_neg_hi", 64'(Hi), 64'hFFFFFFFF);
      applyStimulus(3'd4, 32'h11, 32'h0, -1);
      applyStimulus(3'd5, 32'h22, 32'h0, -1);
      applyStimulus(3'd2, 32'd100, 32'd0, -1);
      checkOutput("dbz_hold_hi", 64'(Hi), 64'h11);
      checkOutput("dbz_hold_lo", 64'(Lo), 64'h22);
      applyStimulus(3'd4, 32'hDEADBEEF, 32'h0, -1);
      applyStimulus(3'd5, 32'h12345678, 32'h0, -1);
      checkOutput("mthi_value", 64'(Hi), 64'hDEADBEEF);
      applyStimulus(3'd0, 32'd5, 32'd6, 10);
      checkOutput("ignored_start_lo", 64'(Lo), 64'd30);
      checkOutput("ignored_start_hi", 64'(Hi), 64'd0);
      applyStimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, -1);
      checkOutput("div_wrap_lo", 64'(Lo), 64'h80000000);
      checkOutput("div_wrap_hi", 64'(Hi), 64'h0);
      applyStimulus(3'd7, 32'h5, 32'h5, -1);

      // Reset in the middle of a multiply aborts it without a Done.
      Start = 1'b1; Op = 3'd0; Operand_A = 32'd5; Operand_B = 32'd6;
      @(negedge Clock);
      Start = 1'b0;
      repeat (14) @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      checkOutput("midreset_busy", 64'(Busy), 64'd0);
      checkOutput("midreset_hi", 64'(Hi), 64'd0);
      checkOutput("midreset_lo", 64'(Lo), 64'd0);
      model_hi = '0;
      model_lo = '0;
      @(negedge Clock);
      Reset = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge Clock);
         if (Done || Busy) done_seen++;
      end
      checkOutput("midreset_no_done", 64'(done_seen), 64'd0);

      // Back-to-back: the second request lands in the DONE cycle of the first.
      applyStimulus(3'd0, 32'd5, 32'd6, -1);
      applyStimulus(3'd2, 32'd1000, 32'd7, -1);
      checkOutput("b2b_lo", 64'(Lo), 64'd142);
      checkOutput("b2b_hi", 64'(Hi), 64'd6);

      // Randomized operations, often issued in the DONE cycle of the
      // previous one.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge Clock);
         applyStimulus(3'($urandom_range(0, 7)), pickValue(), pickValue(), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
